// File: rtl/nios2_mult_pkg.sv
// Op encodings and operand-signedness helpers for the Nios II multiplier.
package nios2_mult_pkg;

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULXSS = 2'b01;
  localparam logic [1:0] OP_MULXSU = 2'b10;
  localparam logic [1:0] OP_MULXUU = 2'b11;

  // High half of the product is returned for every op except MUL.
  function automatic logic op_is_hi(input logic [1:0] op);
    return op != OP_MUL;
  endfunction

  // MUL only needs the low half, which does not depend on signedness.
  function automatic logic op_a_signed(input logic [1:0] op);
    return (op == OP_MULXSS) || (op == OP_MULXSU);
  endfunction

  function automatic logic op_b_signed(input logic [1:0] op);
    return op == OP_MULXSS;
  endfunction

endpackage

// File: rtl/nios2_mult_pp.sv
// Registered signed partial-product multiplier with clock enable.
module nios2_mult_pp #(
  parameter int unsigned HW = 17
) (
  input  logic                   clk,
  input  logic                   en,
  input  logic signed [HW-1:0]   a,
  input  logic signed [HW-1:0]   b,
  output logic signed [2*HW-1:0] p
);

  // Product register; holds while the pipeline is stalled.
  always_ff @(posedge clk) begin
    if (en) p <= a * b;
  end

endmodule

// File: rtl/nios2_mult_pipe.sv
// Three-stage pipelined multiplier returning the low or high product half,
// with valid/ready flow control, tag passthrough and flush.
module nios2_mult_pipe
  import nios2_mult_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned TAG_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_op,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [TAG_W-1:0]  in_tag,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [TAG_W-1:0]  out_tag
);

  localparam int unsigned H   = DATA_W / 2;
  localparam int unsigned PW  = H + 1;
  localparam int unsigned PPW = 2 * PW;
  localparam int unsigned EXT = 2 * DATA_W - PPW;

  logic              stall;
  logic              advance;

  logic              v1;
  logic [1:0]        op1;
  logic [DATA_W-1:0] a1;
  logic [DATA_W-1:0] b1;
  logic [TAG_W-1:0]  tag1;

  logic              v2;
  logic              hi2;
  logic [TAG_W-1:0]  tag2;

  logic              a_sign;
  logic              b_sign;
  logic [PW-1:0]     al;
  logic [PW-1:0]     ah;
  logic [PW-1:0]     bl;
  logic [PW-1:0]     bh;
  logic [PPW-1:0]    p_ll;
  logic [PPW-1:0]    p_lh;
  logic [PPW-1:0]    p_hl;
  logic [PPW-1:0]    p_hh;
  logic [2*DATA_W-1:0] sum;

  // Flow control: a stalled output freezes every stage, bubbles included.
  always_comb begin
    stall    = out_valid & ~out_ready;
    advance  = ~stall;
    in_ready = ~stall & ~flush & ~reset;
  end

  // S1: operand/op/tag capture.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      v1 <= 1'b0;
    end else if (advance) begin
      v1 <= in_valid & in_ready;
    end
    if (advance) begin
      op1  <= in_op;
      a1   <= in_a;
      b1   <= in_b;
      tag1 <= in_tag;
    end
  end

  // Split operands into halves; the upper half carries the op-dependent sign bit,
  // the lower half is always a non-negative (H+1)-bit value.
  always_comb begin
    a_sign = op_a_signed(op1) & a1[DATA_W-1];
    b_sign = op_b_signed(op1) & b1[DATA_W-1];
    al     = {1'b0, a1[H-1:0]};
    ah     = {a_sign, a1[DATA_W-1:H]};
    bl     = {1'b0, b1[H-1:0]};
    bh     = {b_sign, b1[DATA_W-1:H]};
  end

  nios2_mult_pp #(.HW(PW)) u_pp_ll (.clk(clk), .en(advance), .a(al), .b(bl), .p(p_ll));
  nios2_mult_pp #(.HW(PW)) u_pp_lh (.clk(clk), .en(advance), .a(al), .b(bh), .p(p_lh));
  nios2_mult_pp #(.HW(PW)) u_pp_hl (.clk(clk), .en(advance), .a(ah), .b(bl), .p(p_hl));
  nios2_mult_pp #(.HW(PW)) u_pp_hh (.clk(clk), .en(advance), .a(ah), .b(bh), .p(p_hh));

  // S2: control alongside the partial-product registers.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      v2 <= 1'b0;
    end else if (advance) begin
      v2 <= v1;
    end
    if (advance) begin
      hi2  <= op_is_hi(op1);
      tag2 <= tag1;
    end
  end

  // Sign-extend each partial product and sum modulo 2^(2*DATA_W).
  always_comb begin
    sum = ({{EXT{p_hh[PPW-1]}}, p_hh} << DATA_W)
        + (({{EXT{p_lh[PPW-1]}}, p_lh} + {{EXT{p_hl[PPW-1]}}, p_hl}) << H)
        +  {{EXT{p_ll[PPW-1]}}, p_ll};
  end

  // S3: output register with half select.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_tag    <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (advance) begin
      out_valid  <= v2;
      out_result <= hi2 ? sum[2*DATA_W-1:DATA_W] : sum[DATA_W-1:0];
      out_tag    <= tag2;
    end
  end

endmodule

// File: tb/tb_nios2_mult_pipe.sv
// Bench for nios2_mult_pipe: directed cases on a 32-bit instance, then random
// traffic on 32- and 16-bit instances checked through expected-result queues.
module tb_nios2_mult_pipe;

  typedef struct packed {
    logic [4:0]  tag;
    logic [31:0] res;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;

  logic        in_valid, in_ready, out_valid, out_ready;
  logic [1:0]  in_op;
  logic [31:0] in_a, in_b, out_result;
  logic [4:0]  in_tag, out_tag;

  logic        in_valid16, in_ready16, out_valid16, out_ready16, flush16;
  logic [1:0]  in_op16;
  logic [15:0] in_a16, in_b16, out_result16;
  logic [4:0]  in_tag16, out_tag16;

  exp_t q32[$];
  exp_t q16[$];
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  nios2_mult_pipe #(.DATA_W(32), .TAG_W(5)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_tag(out_tag)
  );

  nios2_mult_pipe #(.DATA_W(16), .TAG_W(5)) dut16 (
    .clk(clk), .reset(reset), .in_valid(in_valid16), .in_ready(in_ready16),
    .in_op(in_op16), .in_a(in_a16), .in_b(in_b16), .in_tag(in_tag16), .flush(flush16),
    .out_valid(out_valid16), .out_ready(out_ready16), .out_result(out_result16),
    .out_tag(out_tag16)
  );

  // Golden model: extend to 64 bits, multiply, select the half.
  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input int w);
    logic [63:0] m, ea, eb, p;
    m  = (w == 32) ? 64'h0000_0000_FFFF_FFFF : 64'h0000_0000_0000_FFFF;
    ea = {32'b0, a} & m;
    eb = {32'b0, b} & m;
    if ((op == 2'b01 || op == 2'b10) && a[w-1]) ea = ea | ~m;
    if (op == 2'b01 && b[w-1]) eb = eb | ~m;
    p = ea * eb;
    if (op == 2'b00) return 32'(p & m);
    return 32'((p >> w) & m);
  endfunction

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard for the 32-bit instance.
  always @(negedge clk) begin
    if (reset || flush) begin
      q32.delete();
    end else begin
      if (out_valid && out_ready) begin
        tests++;
        assert (q32.size() != 0) else begin
          fails++;
          $error("FAIL sb32_unexpected: got tag %0h expected no output", out_tag);
        end
        if (q32.size() != 0) begin
          exp_t e;
          e = q32.pop_front();
          chk("sb32_result", 64'(out_result), 64'(e.res));
          chk("sb32_tag", 64'(out_tag), 64'(e.tag));
        end
      end
      if (in_valid && in_ready)
        q32.push_back('{tag: in_tag, res: model(in_op, in_a, in_b, 32)});
    end
  end

  // Scoreboard for the 16-bit instance.
  always @(negedge clk) begin
    if (reset) begin
      q16.delete();
    end else begin
      if (out_valid16 && out_ready16) begin
        tests++;
        assert (q16.size() != 0) else begin
          fails++;
          $error("FAIL sb16_unexpected: got tag %0h expected no output", out_tag16);
        end
        if (q16.size() != 0) begin
          exp_t e;
          e = q16.pop_front();
          chk("sb16_result", 64'(out_result16), 64'(e.res));
          chk("sb16_tag", 64'(out_tag16), 64'(e.tag));
        end
      end
      if (in_valid16 && in_ready16)
        q16.push_back('{tag: in_tag16, res: model(in_op16, {16'b0, in_a16}, {16'b0, in_b16}, 16)});
    end
  end

  // One op on an idle pipe: check 3-edge latency and the result.
  task automatic single(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] tag, input logic [31:0] exp);
    int lat;
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_tag = tag;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      tick();
      lat++;
    end
    chk({name, "_lat"}, 64'(lat), 64'd3);
    chk({name, "_res"}, 64'(out_result), 64'(exp));
    chk({name, "_tag"}, 64'(out_tag), 64'(tag));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int waited;
    reset = 1'b1; flush = 1'b0; flush16 = 1'b0;
    in_valid = 1'b0; in_op = 2'b00; in_a = '0; in_b = '0; in_tag = '0; out_ready = 1'b1;
    in_valid16 = 1'b0; in_op16 = 2'b00; in_a16 = '0; in_b16 = '0; in_tag16 = '0; out_ready16 = 1'b1;
    tick(); tick(); tick();

    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_result", 64'(out_result), 64'd0);
    chk("rst_out_tag", 64'(out_tag), 64'd0);
    reset = 1'b0;
    tick();
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);

    single("uu_ff", 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 32'hFFFF_FFFE);
    single("mul_ff", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8, 32'h0000_0001);
    single("ss_ff", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9, 32'h0000_0000);
    single("ss_min", 2'b01, 32'h8000_0000, 32'h8000_0000, 5'd10, 32'h4000_0000);
    single("su_m1x2", 2'b10, 32'hFFFF_FFFF, 32'h0000_0002, 5'd11, 32'hFFFF_FFFF);
    single("uu_m1x2", 2'b11, 32'hFFFF_FFFF, 32'h0000_0002, 5'd12, 32'h0000_0001);
    tick();

    // Stall: three back-to-back ops, consumer not ready for 5 cycles.
    out_ready = 1'b0;
    in_valid = 1'b1; in_op = 2'b00; in_a = 32'd3; in_b = 32'd5; in_tag = 5'd1;
    tick();
    in_a = 32'd6; in_b = 32'd7; in_tag = 5'd2;
    tick();
    in_op = 2'b11; in_a = 32'hFFFF_FFFF; in_b = 32'd16; in_tag = 5'd3;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", 64'(out_valid), 64'd1);
      chk("stall_in_ready", 64'(in_ready), 64'd0);
      chk("stall_tag", 64'(out_tag), 64'd1);
      chk("stall_result", 64'(out_result), 64'd15);
      tick();
    end
    out_ready = 1'b1;
    chk("drain_tag1", 64'(out_tag), 64'd1);
    tick();
    chk("drain_valid2", 64'(out_valid), 64'd1);
    chk("drain_tag2", 64'(out_tag), 64'd2);
    chk("drain_res2", 64'(out_result), 64'd42);
    tick();
    chk("drain_tag3", 64'(out_tag), 64'd3);
    chk("drain_res3", 64'(out_result), 64'd15);
    tick();
    chk("drain_empty", 64'(out_valid), 64'd0);

    // Flush one cycle after the second op is accepted.
    in_valid = 1'b1; in_op = 2'b00; in_a = 32'd11; in_b = 32'd13; in_tag = 5'd4;
    tick();
    in_tag = 5'd5;
    tick();
    in_tag = 5'd30; flush = 1'b1;
    #1;
    chk("flush_in_ready", 64'(in_ready), 64'd0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("flush_no_out", 64'(out_valid), 64'd0);
      tick();
    end
    single("post_flush", 2'b11, 32'h1234_5678, 32'h9ABC_DEF0, 5'd6,
           model(2'b11, 32'h1234_5678, 32'h9ABC_DEF0, 32));
    tick();

    // Reset with two ops in flight drops them and clears the output register.
    in_valid = 1'b1; in_op = 2'b01; in_a = 32'h0000_1234; in_b = 32'hFFFF_0000; in_tag = 5'd20;
    tick();
    in_tag = 5'd21;
    tick();
    in_valid = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_valid", 64'(out_valid), 64'd0);
    chk("midrst_result", 64'(out_result), 64'd0);
    chk("midrst_tag", 64'(out_tag), 64'd0);
    for (int i = 0; i < 4; i++) begin
      chk("midrst_dropped", 64'(out_valid), 64'd0);
      tick();
    end

    // Random traffic with random back-pressure on both widths.
    for (int i = 0; i < 400; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_op = 2'($urandom_range(0, 3));
      in_a = $urandom; in_b = $urandom; in_tag = 5'($urandom_range(0, 31));
      if (($urandom_range(0, 7)) == 0) in_a = 32'h8000_0000;
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid16 = 1'($urandom_range(0, 1));
      in_op16 = 2'($urandom_range(0, 3));
      in_a16 = 16'($urandom); in_b16 = 16'($urandom); in_tag16 = 5'($urandom_range(0, 31));
      out_ready16 = ($urandom_range(0, 3) != 0);
      tick();
    end
    in_valid = 1'b0; in_valid16 = 1'b0; out_ready = 1'b1; out_ready16 = 1'b1;
    waited = 0;
    while ((q32.size() != 0 || q16.size() != 0) && waited < 20) begin
      tick();
      waited++;
    end
    chk("rand_q32_drained", 64'(q32.size()), 64'd0);
    chk("rand_q16_drained", 64'(q16.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
